ddr_sample_trigger: RTL and testbench

DDR_SAMPLE_TRIGGER -- requirements
Module: ddr_sample_trigger

---
 rtl/ddr_sample_trigger.sv | 211 +++++++++++++++++++++
 tb/tb_ddr_sample_trigger.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_sample_trigger.sv
// ddr_sample_trigger
//   Threshold trigger for a DDR ADC stream carrying two 12-bit samples per
//   clock. A slow IIR baseline follows the signal while idle. A trigger fires
//   once enough consecutive samples exceed the baseline by more than
//   THRESHOLD. The peak excess of each event is reported when the event ends,
//   and a holdoff period follows before the next trigger can fire.
//
// Ports
//   CLK        : sole clock, rising edge
//   RESET      : synchronous, active-high reset
//   DATA_IN    : [11:0] sample A (earlier), [23:12] sample B (later)
//   ENABLE     : trigger enable; low aborts an event in progress
//   THRESHOLD  : excess threshold in ADC counts (strictly greater is "over")
//   MIN_WIDTH  : consecutive over-threshold samples needed (0 behaves as 1)
//   HOLDOFF    : holdoff length in CLK cycles after an event ends
//   TRIG       : one-cycle trigger pulse
//   BUSY       : high while an event or its holdoff is in progress
//   PEAK       : maximum excess of the last completed event
//   PEAK_VALID : one-cycle pulse when PEAK updates
//   BASELINE   : current baseline estimate
//   TRIG_COUNT : number of triggers, wrapping
module ddr_sample_trigger #(
  parameter int BL_SHIFT = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] DATA_IN,
  input  logic        ENABLE,
  input  logic [11:0] THRESHOLD,
  input  logic [3:0]  MIN_WIDTH,
  input  logic [7:0]  HOLDOFF,
  output logic        TRIG,
  output logic        BUSY,
  output logic [11:0] PEAK,
  output logic        PEAK_VALID,
  output logic [11:0] BASELINE,
  output logic [15:0] TRIG_COUNT
);

  localparam int ACC_W = 12 + BL_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HOLDOFF
  } state_t;

  state_t             r_state;
  logic [23:0]        r_din;
  logic               r_din_valid;
  logic               r_preload_armed;
  logic [ACC_W-1:0]   r_acc;
  logic [3:0]         r_run;
  logic [7:0]         r_ho_cnt;
  logic [11:0]        r_peak_trk;
  logic [11:0]        r_peak;
  logic               r_peak_valid;
  logic               r_trig;
  logic               r_busy;
  logic [15:0]        r_trig_count;

  logic [11:0]        w_a;
  logic [11:0]        w_b;
  logic [12:0]        w_sum;
  logic [11:0]        w_avg;
  logic [11:0]        w_baseline;
  logic [ACC_W-1:0]   w_acc_next;
  logic signed [12:0] w_exc_a;
  logic signed [12:0] w_exc_b;
  logic signed [12:0] w_thr_s;
  logic               w_track;
  logic               w_over_a;
  logic               w_over_b;
  logic [4:0]         w_run_p2;
  logic [3:0]         w_run_next;
  logic [3:0]         w_min_eff;
  logic               w_fire;
  logic [11:0]        w_peak_upd;

  assign w_a        = r_din[11:0];
  assign w_b        = r_din[23:12];
  assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
  assign w_avg      = 12'(w_sum >> 1);
  assign w_baseline = r_acc[ACC_W-1:BL_SHIFT];

  // Leaky integrator: ACC converges to AVG << BL_SHIFT. The result always
  // fits in ACC_W bits because ACC >> BL_SHIFT never exceeds 4095.
  assign w_acc_next = r_acc + ACC_W'(w_avg) - ACC_W'(w_baseline);

  assign w_exc_a = $signed({1'b0, w_a}) - $signed({1'b0, w_baseline});
  assign w_exc_b = $signed({1'b0, w_b}) - $signed({1'b0, w_baseline});
  assign w_thr_s = $signed({1'b0, THRESHOLD});

  // Until the baseline has been preloaded it is meaningless, so no sample
  // may count as over before then.
  assign w_track  = r_din_valid & ~r_preload_armed;
  assign w_over_a = w_track && (w_exc_a > w_thr_s);
  assign w_over_b = w_track && (w_exc_b > w_thr_s);

  assign w_run_p2  = {1'b0, r_run} + 5'd2;
  assign w_min_eff = (MIN_WIDTH == 4'd0) ? 4'd1 : MIN_WIDTH;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_run_next = 4'd0;
    if (w_over_a && w_over_b) begin
      w_run_next = (w_run_p2 > 5'd15) ? 4'd15 : w_run_p2[3:0];
    end else if (w_over_b) begin
      // B is the later sample, so a lone B-over starts a fresh run.
      w_run_next = 4'd1;
    end

    w_peak_upd = r_peak_trk;
    if (w_over_a && (w_exc_a[11:0] > w_peak_upd)) begin
      w_peak_upd = w_exc_a[11:0];
    end
    if (w_over_b && (w_exc_b[11:0] > w_peak_upd)) begin
      w_peak_upd = w_exc_b[11:0];
    end
  end

  assign w_fire = (r_state == S_IDLE) && ENABLE && (w_run_next >= w_min_eff);

  // NOTE: non-blocking assignments throughout, so every register sees the
  // pre-edge value of every other register regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= S_IDLE;
      r_din           <= '0;
      r_din_valid     <= 1'b0;
      r_preload_armed <= 1'b1;
      r_acc           <= '0;
      r_run           <= '0;
      r_ho_cnt        <= '0;
      r_peak_trk      <= '0;
      r_peak          <= '0;
      r_peak_valid    <= 1'b0;
      r_trig          <= 1'b0;
      r_busy          <= 1'b0;
      r_trig_count    <= '0;
    end else begin
      r_din        <= DATA_IN;
      r_din_valid  <= 1'b1;
      r_trig       <= 1'b0;
      r_peak_valid <= 1'b0;

      if (r_din_valid && r_preload_armed) begin
        r_acc           <= {w_avg, {BL_SHIFT{1'b0}}};
        r_preload_armed <= 1'b0;
      end else if (!r_preload_armed && (r_state == S_IDLE)) begin
        r_acc <= w_acc_next;
      end

      case (r_state)
        S_IDLE: begin
          r_run      <= w_run_next;
          r_peak_trk <= (w_run_next == 4'd0) ? 12'd0 : w_peak_upd;
          if (w_fire) begin
            r_state      <= S_ACTIVE;
            r_trig       <= 1'b1;
            r_busy       <= 1'b1;
            r_trig_count <= r_trig_count + 16'd1;
          end
        end

        S_ACTIVE: begin
          r_run <= '0;
          if (!ENABLE) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_peak_trk <= '0;
          end else if (!w_over_a && !w_over_b) begin
            r_state      <= S_HOLDOFF;
            r_peak       <= r_peak_trk;
            r_peak_valid <= 1'b1;
            r_ho_cnt     <= '0;
            r_peak_trk   <= '0;
          end else begin
            r_peak_trk <= w_peak_upd;
          end
        end

        S_HOLDOFF: begin
          r_run <= '0;
          // Compared against the live HOLDOFF so a change shortens or
          // extends a holdoff already in progress.
          if (!ENABLE || (r_ho_cnt >= HOLDOFF)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ho_cnt <= r_ho_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TRIG       = r_trig;
  assign BUSY       = r_busy;
  assign PEAK       = r_peak;
  assign PEAK_VALID = r_peak_valid;
  assign BASELINE   = w_baseline;
  assign TRIG_COUNT = r_trig_count;

endmodule

// File: tb/tb_ddr_sample_trigger.sv
// Testbench for ddr_sample_trigger. Each vector drives one DATA_IN word plus
// controls before a rising edge; the expected outputs are those visible just
// after that edge (which reflect the word driven one vector earlier).
module tb_ddr_sample_trigger;

  logic        clk;
  logic        rst;
  logic [23:0] data_in;
  logic        enable;
  logic [11:0] threshold;
  logic [3:0]  min_width;
  logic [7:0]  holdoff;
  logic        trig;
  logic        busy;
  logic [11:0] peak;
  logic        peak_valid;
  logic [11:0] baseline;
  logic [15:0] trig_count;

  ddr_sample_trigger #(.BL_SHIFT(6)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .DATA_IN    (data_in),
    .ENABLE     (enable),
    .THRESHOLD  (threshold),
    .MIN_WIDTH  (min_width),
    .HOLDOFF    (holdoff),
    .TRIG       (trig),
    .BUSY       (busy),
    .PEAK       (peak),
    .PEAK_VALID (peak_valid),
    .BASELINE   (baseline),
    .TRIG_COUNT (trig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] thr;
    logic [3:0]  mw;
    logic [7:0]  ho;
    logic        e_trig;
    logic        e_busy;
    logic        e_pv;
    logic [11:0] e_peak;
    int          e_bl;     // negative: baseline not checked
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [11:0] F = 12'h100;

  vec_t        tbl[$];
  logic [11:0] cfg_thr;
  logic [3:0]  cfg_mw;
  logic [7:0]  cfg_ho;
  int          n_checks;
  int          n_err;

  function automatic vec_t mk(logic r, logic en, logic [11:0] a, logic [11:0] b,
                              logic t, logic bz, logic pv, logic [11:0] pk,
                              int bl, logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.en = en; v.a = a; v.b = b;
    v.thr = cfg_thr; v.mw = cfg_mw; v.ho = cfg_ho;
    v.e_trig = t; v.e_busy = bz; v.e_pv = pv; v.e_peak = pk;
    v.e_bl = bl; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic void add(logic r, logic en, logic [11:0] a, logic [11:0] b,
                              logic t, logic bz, logic pv, logic [11:0] pk,
                              int bl, logic [15:0] cnt);
    tbl.push_back(mk(r, en, a, b, t, bz, pv, pk, bl, cnt));
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    rst       = v.rst;
    enable    = v.en;
    data_in   = {v.b, v.a};
    threshold = v.thr;
    min_width = v.mw;
    holdoff   = v.ho;
    @(posedge clk);
    #1;
    check("trig",       idx, 32'(trig),       32'(v.e_trig));
    check("busy",       idx, 32'(busy),       32'(v.e_busy));
    check("peak_valid", idx, 32'(peak_valid), 32'(v.e_pv));
    check("peak",       idx, 32'(peak),       32'(v.e_peak));
    check("trig_count", idx, 32'(trig_count), 32'(v.e_cnt));
    if (v.e_bl >= 0) check("baseline", idx, 32'(baseline), 32'(v.e_bl));
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst       = 1'b1;
    enable    = 1'b0;
    data_in   = '0;
    threshold = '0;
    min_width = '0;
    holdoff   = '0;

    // Reset, flat baseline for 200 words, then a two-word pulse.
    cfg_thr = 12'd50; cfg_mw = 4'd3; cfg_ho = 8'd4;
    add(1, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(1, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 199; i++) add(0, 1, F, F, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h100, 12'h140, 0, 0, 0, 0,     'h100, 0);
    add(0, 1, 12'h180, 12'h160, 0, 0, 0, 0,     'h100, 0);
    add(0, 1, F, F,             1, 1, 0, 0,     'h102, 1);
    add(0, 1, F, F,             0, 1, 1, 'h080, 'h102, 1);
    for (int i = 0; i < 4; i++) add(0, 1, F, F, 0, 1, 0, 'h080, 'h102, 1);
    add(0, 1, F, F,             0, 0, 0, 'h080, 'h102, 1);
    add(0, 1, F, F,             0, 0, 0, 'h080, 'h102, 1);

    // ENABLE dropped while ACTIVE: back to IDLE, no PEAK_VALID, PEAK kept.
    cfg_mw = 4'd1;
    add(0, 1, 12'h180, 12'h180, 0, 0, 0, 'h080, 'h102, 1);
    add(0, 1, 12'h180, 12'h180, 1, 1, 0, 'h080, 'h104, 2);
    add(0, 0, F, F,             0, 0, 0, 'h080, 'h104, 2);
    add(0, 1, F, F,             0, 0, 0, 'h080, 'h104, 2);
    add(0, 1, F, F,             0, 0, 0, 'h080, 'h104, 2);

    // A-only-over words never build a run.
    cfg_mw = 4'd2;
    add(1, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h101, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h101, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h101, 0);
    add(0, 1, 12'h140, 12'h100, 0, 0, 0, 0, 'h102, 0);

    // Retrigger inside HOLDOFF=10 is ignored; the same pulse afterwards fires.
    cfg_mw = 4'd3; cfg_ho = 8'd10;
    add(1, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h100, 12'h140, 0, 0, 0, 0,     'h100, 0);
    add(0, 1, 12'h180, 12'h160, 0, 0, 0, 0,     'h100, 0);
    add(0, 1, F, F,             1, 1, 0, 0,     'h102, 1);
    add(0, 1, 12'h100, 12'h140, 0, 1, 1, 'h080, 'h102, 1);
    add(0, 1, 12'h180, 12'h160, 0, 1, 0, 'h080, 'h102, 1);
    for (int i = 0; i < 9; i++) add(0, 1, F, F, 0, 1, 0, 'h080, 'h102, 1);
    add(0, 1, 12'h100, 12'h140, 0, 0, 0, 'h080, 'h102, 1);
    add(0, 1, 12'h180, 12'h160, 0, 0, 0, 'h080, 'h102, 1);
    add(0, 1, F, F,             1, 1, 0, 'h080, 'h104, 2);
    add(0, 1, F, F,             0, 1, 1, 'h07E, 'h104, 2);

    // Excess equal to THRESHOLD is not over; MIN_WIDTH=0 fires on one
    // B-over sample; HOLDOFF=0 leaves HOLDOFF after one cycle.
    cfg_mw = 4'd1; cfg_ho = 8'd0;
    add(1, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 0, 0);
    add(0, 1, F, F, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, 12'h132, 12'h132, 0, 0, 0, 0, 'h100, 0);
    add(0, 1, F, F,             0, 0, 0, 0, 'h100, 0);
    cfg_mw = 4'd0;
    add(0, 1, F, F,             0, 0, 0, 0,     'h100, 0);
    add(0, 1, 12'h100, 12'h140, 0, 0, 0, 0,     'h100, 0);
    add(0, 1, F, F,             1, 1, 0, 0,     'h101, 1);
    add(0, 1, F, F,             0, 1, 1, 'h040, 'h101, 1);
    add(0, 1, F, F,             0, 0, 0, 'h040, 'h101, 1);
    add(0, 1, F, F,             0, 0, 0, 'h040, 'h101, 1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // TRIG_COUNT wrap: preset the counter to 0xFFFF, then trigger once.
    @(negedge clk);
    force dut.r_trig_count = 16'hFFFF;
    #1;
    release dut.r_trig_count;
    run_vec(mk(0, 1, 12'h100, 12'h180, 0, 0, 0, 'h040, -1, 16'hFFFF), 1000);
    run_vec(mk(0, 1, F, F,             1, 1, 0, 'h040, -1, 16'h0000), 1001);

    // Reset while ACTIVE (the event would otherwise end this edge): no
    // PEAK_VALID, everything cleared, then the first word re-preloads.
    run_vec(mk(1, 1, 12'h100, 12'h180, 0, 0, 0, 0, 0,     0), 1002);
    run_vec(mk(0, 1, 12'h200, 12'h200, 0, 0, 0, 0, 0,     0), 1003);
    run_vec(mk(0, 1, 12'h200, 12'h200, 0, 0, 0, 0, 'h200, 0), 1004);
    run_vec(mk(0, 1, 12'h200, 12'h200, 0, 0, 0, 0, 'h200, 0), 1005);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
